// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Holds the FSM state encoding, row count and default expected table.
package tt_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int ROWS = 8;
  localparam logic [7:0] DEFAULT_EXPECTED = 8'h5E;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tt_sweep_if.sv
// Bundle between the test host / gate-under-test side and the sweep controller.
// Handshake: start is a 1-cycle pulse honoured only when the controller is idle and not
// pulsing done; results are valid on the done pulse and held until the next sweep finishes.
interface tt_sweep_if #(
  parameter int SETTLE_W = 8
);
  logic                start;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                in1;
  logic                in2;
  logic                in3;
  logic                gate_out;
  logic                busy;
  logic                done;
  logic [7:0]          observed;
  logic [7:0]          mismatch;
  logic                pass;
  logic [2:0]          first_fail;

  modport master (
    output start, settle_cycles, gate_out,
    input  in1, in2, in3, busy, done, observed, mismatch, pass, first_fail
  );

  modport slave (
    input  start, settle_cycles, gate_out,
    output in1, in2, in3, busy, done, observed, mismatch, pass, first_fail
  );
endinterface

// File: rtl/tt_sweep_ctrl_timer.sv
// Per-row settle counter: load (zero clamped to one), count down, flag the last cycle.
module tt_settle_timer #(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [SETTLE_W-1:0] i_load_val,
  input  logic                i_dec,
  output logic                o_expire
);

  localparam logic [SETTLE_W-1:0] ONE = SETTLE_W'(1);

  logic [SETTLE_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= (i_load_val == '0) ? ONE : i_load_val;
    end else if (i_dec && (r_count > ONE)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_expire = (r_count <= ONE);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps rows 0..7 into an external 3-input gate, waits a settle time per row, captures
// the output and compares the assembled truth table against EXPECTED.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter logic [7:0] EXPECTED = DEFAULT_EXPECTED,
  parameter int         SETTLE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  tt_sweep_if.slave   sif,
  output state_t      o_dbg_state
);

  state_t              r_state;
  logic [2:0]          r_row;
  logic [SETTLE_W-1:0] r_settle;
  logic [7:0]          r_capture;
  logic [2:0]          r_in;
  logic                r_busy;
  logic                r_done;
  logic [7:0]          r_observed;
  logic [7:0]          r_mismatch;
  logic                r_pass;
  logic [2:0]          r_first_fail;

  logic w_timer_load;
  logic w_timer_dec;
  logic w_expire;
  logic [7:0] w_diff;

  assign w_timer_load = (r_state == APPLY);
  assign w_timer_dec  = (r_state == SETTLE);
  assign w_diff       = r_capture ^ EXPECTED;

  tt_settle_timer #(.SETTLE_W(SETTLE_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_timer_load),
    .i_load_val (r_settle),
    .i_dec      (w_timer_dec),
    .o_expire   (w_expire)
  );

  // Capture lives in r_capture during the sweep so the published results only move in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_row        <= 3'd0;
      r_settle     <= '0;
      r_capture    <= 8'd0;
      r_in         <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_observed   <= 8'd0;
      r_mismatch   <= 8'd0;
      r_pass       <= 1'b0;
      r_first_fail <= 3'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A start landing on the done-pulse cycle is dropped.
          if (sif.start && !r_done) begin
            r_settle  <= sif.settle_cycles;
            r_row     <= 3'd0;
            r_capture <= 8'd0;
            r_busy    <= 1'b1;
            r_state   <= APPLY;
          end
        end
        APPLY: begin
          r_in    <= r_row;
          r_state <= SETTLE;
        end
        SETTLE: begin
          if (w_expire) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_capture[r_row] <= sif.gate_out;
          if (r_row == 3'd7) begin
            r_state <= DONE;
          end else begin
            r_row   <= r_row + 3'd1;
            r_state <= APPLY;
          end
        end
        DONE: begin
          r_observed   <= r_capture;
          r_mismatch   <= w_diff;
          r_pass       <= (w_diff == 8'd0);
          r_first_fail <= lowest_set(w_diff);
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sif.in1        = r_in[2];
  assign sif.in2        = r_in[1];
  assign sif.in3        = r_in[0];
  assign sif.busy       = r_busy;
  assign sif.done       = r_done;
  assign sif.observed   = r_observed;
  assign sif.mismatch   = r_mismatch;
  assign sif.pass       = r_pass;
  assign sif.first_fail = r_first_fail;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: directed vector table, reset-mid-sweep sequence, random sweeps.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

  localparam logic [7:0] EXP = 8'h5E;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_sweep_if #(.SETTLE_W(8)) sif ();
  state_t dbg_state;
  logic [7:0] gate_tbl;

  tt_sweep_ctrl #(.EXPECTED(EXP), .SETTLE_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .sif         (sif.slave),
    .o_dbg_state (dbg_state)
  );

  // Gate under test: a pure lookup of the current input row.
  assign sif.gate_out = gate_tbl[{sif.in1, sif.in2, sif.in3}];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] exp_q[$];
  logic [7:0] prev_obs, prev_mis;
  logic       prev_pass;
  logic [2:0] prev_ff, prev_pins;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_latency(input int settle);
    int eff;
    eff = (settle == 0) ? 1 : settle;
    return 8 * (eff + 2) + 1;
  endfunction

  function automatic logic [2:0] model_ff(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Row on the gate pins k cycles after the accepting edge (k >= 1).
  function automatic logic [2:0] model_row(input int k, input int settle);
    int eff, r;
    eff = (settle == 0) ? 1 : settle;
    r = (k - 1) / (eff + 2);
    return (r > 7) ? 3'd7 : 3'(r);
  endfunction

  function automatic logic [2:0] pins();
    return {sif.in1, sif.in2, sif.in3};
  endfunction

  // ---------------- driver ----------------
  task automatic run_sweep(input string tag, input logic [7:0] tbl, input int settle,
                           input logic [7:0] e_obs, input logic [7:0] e_mis,
                           input logic [2:0] e_ff, input bit e_pass, input int e_lat,
                           input int extra_k, input bit coinc);
    int pin_err, busy_err, done_err, hold_err;
    logic [19:0] rec;
    pin_err = 0; busy_err = 0; done_err = 0; hold_err = 0;
    exp_q.push_back({e_obs, e_mis, e_ff, e_pass});
    gate_tbl = tbl;
    @(negedge clk);
    sif.settle_cycles = 8'(settle);
    sif.start = 1'b1;
    for (int k = 0; k <= e_lat; k++) begin
      @(negedge clk);
      if (k == 0) sif.start = 1'b0;
      if (k == extra_k) sif.start = 1'b1;
      else if (k == extra_k + 1) sif.start = 1'b0;
      sif.settle_cycles = 8'($urandom_range(0, 255));
      if (pins() !== ((k == 0) ? prev_pins : model_row(k, settle))) pin_err++;
      if (k < e_lat) begin
        if (sif.done !== 1'b0) done_err++;
        if (sif.busy !== 1'b1) busy_err++;
        if (sif.observed !== prev_obs || sif.mismatch !== prev_mis ||
            sif.pass !== prev_pass || sif.first_fail !== prev_ff) hold_err++;
      end
    end
    sif.start = 1'b0;
    rec = exp_q.pop_front();
    check({tag, " done"}, 32'(sif.done), 32'd1);
    check({tag, " busy_end"}, 32'(sif.busy), 32'd0);
    check({tag, " observed"}, 32'(sif.observed), 32'(rec[19:12]));
    check({tag, " mismatch"}, 32'(sif.mismatch), 32'(rec[11:4]));
    check({tag, " first_fail"}, 32'(sif.first_fail), 32'(rec[3:1]));
    check({tag, " pass"}, 32'(sif.pass), 32'(rec[0]));
    check({tag, " pin_order_errs"}, pin_err, 0);
    check({tag, " busy_errs"}, busy_err, 0);
    check({tag, " early_done_errs"}, done_err, 0);
    check({tag, " hold_errs"}, hold_err, 0);
    if (coinc) sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    check({tag, " done_pulse"}, 32'(sif.done), 32'd0);
    check({tag, " pins_hold"}, 32'(pins()), 32'd7);
    if (coinc) begin
      @(negedge clk);
      check({tag, " coinc_start_ignored"}, 32'(sif.busy), 32'd0);
    end
    prev_obs = e_obs; prev_mis = e_mis; prev_pass = e_pass; prev_ff = e_ff; prev_pins = 3'd7;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] tbl;
    int         settle;
    int         extra_k;
    bit         coinc;
    logic [7:0] e_obs;
    logic [7:0] e_mis;
    logic [2:0] e_ff;
    bit         e_pass;
    int         e_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h5E, 3,   -1, 1'b0, 8'h5E, 8'h00, 3'd0, 1'b1, 41};
    vecs[1] = '{8'h7E, 2,   -1, 1'b0, 8'h7E, 8'h20, 3'd5, 1'b0, 33};
    vecs[2] = '{8'h5E, 0,   -1, 1'b0, 8'h5E, 8'h00, 3'd0, 1'b1, 25};
    vecs[3] = '{8'h5E, 3,   10, 1'b0, 8'h5E, 8'h00, 3'd0, 1'b1, 41};
    vecs[4] = '{8'hA1, 1,   -1, 1'b0, 8'hA1, 8'hFF, 3'd0, 1'b0, 25};
    vecs[5] = '{8'h5F, 5,   -1, 1'b0, 8'h5F, 8'h01, 3'd0, 1'b0, 57};
    vecs[6] = '{8'hDE, 4,   -1, 1'b1, 8'hDE, 8'h80, 3'd7, 1'b0, 49};
    vecs[7] = '{8'h1E, 255, -1, 1'b0, 8'h1E, 8'h40, 3'd6, 1'b0, 2057};

    rst = 1'b1;
    sif.start = 1'b0;
    sif.settle_cycles = 8'd0;
    gate_tbl = 8'h00;
    prev_obs = 8'd0; prev_mis = 8'd0; prev_pass = 1'b0; prev_ff = 3'd0; prev_pins = 3'd0;
    repeat (3) @(negedge clk);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    check("reset pins", 32'(pins()), 32'd0);
    check("reset busy", 32'(sif.busy), 32'd0);
    check("reset done", 32'(sif.done), 32'd0);
    check("reset results", {sif.observed, sif.mismatch, 5'(sif.first_fail), 3'(sif.pass)},
          32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_sweep($sformatf("vec%0d", i), vecs[i].tbl, vecs[i].settle, vecs[i].e_obs,
                vecs[i].e_mis, vecs[i].e_ff, vecs[i].e_pass, vecs[i].e_lat,
                vecs[i].extra_k, vecs[i].coinc);
    end

    // Reset during SETTLE of row 4 with settle = 3.
    gate_tbl = 8'h5E;
    @(negedge clk);
    sif.settle_cycles = 8'd3;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (22) @(negedge clk);
    check("pre_reset row4", 32'(pins()), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("midreset pins", 32'(pins()), 32'd0);
    check("midreset busy", 32'(sif.busy), 32'd0);
    check("midreset done", 32'(sif.done), 32'd0);
    check("midreset results", {sif.observed, sif.mismatch, 5'(sif.first_fail), 3'(sif.pass)},
          32'd0);
    rst = 1'b0;
    prev_obs = 8'd0; prev_mis = 8'd0; prev_pass = 1'b0; prev_ff = 3'd0; prev_pins = 3'd0;
    exp_q.delete();
    run_sweep("after_reset", 8'h5E, 3, 8'h5E, 8'h00, 3'd0, 1'b1, 41, -1, 1'b0);

    // Random tables and settle times against the model.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] t;
      int s;
      t = 8'($urandom_range(0, 255));
      s = $urandom_range(0, 6);
      run_sweep($sformatf("rand%0d", i), t, s, t, t ^ EXP, model_ff(t ^ EXP),
                (t == EXP), model_latency(s), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
